nibble_serial_add_ctrl: RTL



---
 rtl/nibble_serial_add_ctrl_if.sv | 32 +++
 rtl/nibble_serial_add_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl_if
// Brief    : Request/result bundle between a requester and the nibble-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl (plus four_bit_adder slice)
// Brief    : Wide add done one nibble per clock through a shared 4-bit adder.
//            Define NIBBLE_SERIAL_OVF_EN to enable the signed-overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module four_bit_adder (
    output logic [3:0] s,
    output logic       c,
    input  wire  [3:0] A,
    input  wire  [3:0] B,
    input  wire        cin
);
    assign {c, s} = {1'b0, A} + {1'b0, B} + {4'b0000, cin};
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int                W        = 4 * NIBBLES;
    localparam int                IDXW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IDXW-1:0] idx_q,   idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic [W-1:0]    acc_q,   acc_d;
    logic [W-1:0]    sum_q,   sum_d;
    logic            cout_q,  cout_d;

    logic [3:0] w_nib_a;
    logic [3:0] w_nib_b;
    logic [3:0] w_nib_s;
    logic       w_nib_c;
    logic       w_last;

    // {idx,2'b00} keeps the slice offset wide enough for every legal NIBBLES
    assign w_nib_a = a_q[{idx_q, 2'b00} +: 4];
    assign w_nib_b = b_q[{idx_q, 2'b00} +: 4];
    assign w_last  = (state_q == S_ADD) && (idx_q == LAST_IDX);

    four_bit_adder u_adder (
        .s   (w_nib_s),
        .c   (w_nib_c),
        .A   (w_nib_a),
        .B   (w_nib_b),
        .cin (carry_q)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                acc_d[{idx_q, 2'b00} +: 4] = w_nib_s;
                carry_d = w_nib_c;
                idx_d   = idx_q + IDXW'(1);
                if (w_last) begin
                    sum_d   = acc_d;
                    cout_d  = w_nib_c;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == S_ADD);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

`ifdef NIBBLE_SERIAL_OVF_EN
    logic ovf_q;

    // Two's-complement overflow: like-signed operands giving an opposite-signed result
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (w_last) begin
            ovf_q <= (w_nib_a[3] == w_nib_b[3]) && (w_nib_s[3] != w_nib_a[3]);
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule
`default_nettype wire
